// File: rtl/scb_clear_arbiter_if.sv
// Scoreboard-clear bus: per-source request side plus the single clear port
// that feeds the scoreboard. The arbiter uses the slave modport.
interface scb_clear_arbiter_if #(
    parameter int NUM_WARPS    = 8,
    parameter int LOGNUM_WARPS = $clog2(NUM_WARPS),
    parameter int NUM_SRC      = 3
);
    logic [NUM_SRC-1:0]              Clear_Valid_In;
    logic [LOGNUM_WARPS*NUM_SRC-1:0] Clear_WarpID_In;
    logic [2*NUM_SRC-1:0]            Clear_ScbID_In;
    logic [NUM_SRC-1:0]              Clear_Ready_Out;
    logic [NUM_SRC-1:0]              Pending_Out;
    logic                            Clear_Valid_ALU_Scb;
    logic [LOGNUM_WARPS-1:0]         Clear_WarpID_ALU_Scb;
    logic [1:0]                      Clear_ScbID_ALU_Scb;

    modport master (
        output Clear_Valid_In, Clear_WarpID_In, Clear_ScbID_In,
        input  Clear_Ready_Out, Pending_Out,
        input  Clear_Valid_ALU_Scb, Clear_WarpID_ALU_Scb, Clear_ScbID_ALU_Scb
    );

    modport slave (
        input  Clear_Valid_In, Clear_WarpID_In, Clear_ScbID_In,
        output Clear_Ready_Out, Pending_Out,
        output Clear_Valid_ALU_Scb, Clear_WarpID_ALU_Scb, Clear_ScbID_ALU_Scb
    );
endinterface

// File: rtl/scb_clear_arbiter.sv
// Scoreboard clear arbiter: one small FIFO per writeback source, drained by a
// round-robin arbiter into a registered single-clear-per-cycle output port.
module scb_clear_arbiter #(
    parameter int NUM_WARPS    = 8,
    parameter int LOGNUM_WARPS = $clog2(NUM_WARPS),
    parameter int NUM_SRC      = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    scb_clear_arbiter_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int EW = LOGNUM_WARPS + 2;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] LAST_RST = SW'(NUM_SRC - 1);

    logic [NUM_SRC-1:0]         ready;
    logic [NUM_SRC-1:0]         pending;
    logic [NUM_SRC-1:0]         push;
    logic [NUM_SRC-1:0]         pop;
    logic [NUM_SRC-1:0][EW-1:0] head;

    logic [SW-1:0]           last_q, last_d;
    logic [SW-1:0]           win_idx;
    logic [SW-1:0]           cand;
    logic                    win_found;
    logic                    valid_q, valid_d;
    logic [LOGNUM_WARPS-1:0] warp_q, warp_d;
    logic [1:0]              scb_q, scb_d;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        logic [EW-1:0] mem_q [FIFO_DEPTH];
        logic [PW-1:0] wr_ptr_q, wr_ptr_d;
        logic [PW-1:0] rd_ptr_q, rd_ptr_d;
        logic [CW-1:0] count_q, count_d;

        // Ready looks only at the registered count, so a pop never frees a slot early.
        assign ready[g]   = (count_q < DEPTH_C);
        assign pending[g] = (count_q != '0);
        assign push[g]    = bus.Clear_Valid_In[g] && ready[g];
        assign head[g]    = mem_q[rd_ptr_q];

        // FIFO pointer/count next state.
        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (push[g]) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop[g])  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push[g], pop[g]})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        // FIFO pointer/count registers; reset discards all queued clears.
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        // FIFO storage write; contents are don't-care while count is zero.
        always_ff @(posedge clk) begin
            if (push[g]) begin
                mem_q[wr_ptr_q] <= {bus.Clear_WarpID_In[g*LOGNUM_WARPS +: LOGNUM_WARPS],
                                    bus.Clear_ScbID_In[2*g +: 2]};
            end
        end
    end

    // Round-robin search starting one past the last grant, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = '0;
        pop       = '0;
        for (int unsigned k = 1; k <= unsigned'(NUM_SRC); k++) begin
            cand = SW'((32'(last_q) + k) % unsigned'(NUM_SRC));
            if (!win_found && pending[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        if (win_found) pop[win_idx] = 1'b1;
    end

    // Output stage next state; ID fields hold when no clear is issued.
    always_comb begin
        last_d  = last_q;
        valid_d = win_found;
        warp_d  = warp_q;
        scb_d   = scb_q;
        if (win_found) begin
            last_d          = win_idx;
            {warp_d, scb_d} = head[win_idx];
        end
    end

    // Output stage and grant pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= LAST_RST;
            valid_q <= 1'b0;
            warp_q  <= '0;
            scb_q   <= '0;
        end else begin
            last_q  <= last_d;
            valid_q <= valid_d;
            warp_q  <= warp_d;
            scb_q   <= scb_d;
        end
    end

    assign bus.Clear_Ready_Out      = ready;
    assign bus.Pending_Out          = pending;
    assign bus.Clear_Valid_ALU_Scb  = valid_q;
    assign bus.Clear_WarpID_ALU_Scb = warp_q;
    assign bus.Clear_ScbID_ALU_Scb  = scb_q;

    a_one_pop:      assert property (@(posedge clk) disable iff (rst) $onehot0(pop));
    a_push_ready:   assert property (@(posedge clk) disable iff (rst) (push & ~ready) == '0);
    a_pop_pending:  assert property (@(posedge clk) disable iff (rst) (pop & ~pending) == '0);
    a_valid_popped: assert property (@(posedge clk) disable iff (rst)
                                     valid_q |-> $past($onehot(pop)));
endmodule

// File: tb/tb_scb_clear_arbiter.sv
// Bench for scb_clear_arbiter: transaction-level model with an expected-clear
// queue checked every cycle, a table of isolated push patterns with
// hand-derived output order, and directed fill/fairness/reset sequences.
module tb_scb_clear_arbiter;
    localparam int NS    = 3;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [2:0] w;
        logic [1:0] s;
    } clr_t;

    typedef struct packed {
        logic [2:0]      mask;
        logic [2:0][2:0] w;
        logic [2:0][1:0] s;
        logic [1:0]      n;
        logic [2:0][2:0] ew;
        logic [2:0][1:0] es;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] vin = '0;
    logic [2:0] vw [NS];
    logic [1:0] vs [NS];
    logic [2:0] acc;

    clr_t       mq [NS][$];
    clr_t       exp_q [$];
    int         m_last;
    logic [2:0] m_warp;
    logic [1:0] m_scb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scb_clear_arbiter_if #(.NUM_WARPS(8), .LOGNUM_WARPS(3), .NUM_SRC(NS)) bus ();

    assign bus.Clear_Valid_In  = vin;
    assign bus.Clear_WarpID_In = {vw[2], vw[1], vw[0]};
    assign bus.Clear_ScbID_In  = {vs[2], vs[1], vs[0]};

    scb_clear_arbiter #(
        .NUM_WARPS(8), .LOGNUM_WARPS(3), .NUM_SRC(NS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: update the model at the edge, compare DUT at the following negedge.
    task automatic step();
        logic [NS-1:0] rdy_pre;
        int            win;
        clr_t          it;
        acc = '0;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            exp_q.delete();
            m_last = NS - 1;
            m_warp = '0;
            m_scb  = '0;
        end else begin
            for (int i = 0; i < NS; i++) rdy_pre[i] = (mq[i].size() < DEPTH);
            win = -1;
            for (int k = 1; k <= NS; k++) begin
                int idx;
                idx = (m_last + k) % NS;
                if (win < 0 && mq[idx].size() > 0) win = idx;
            end
            if (win >= 0) begin
                it = mq[win].pop_front();
                exp_q.push_back(it);
                m_last = win;
            end
            for (int i = 0; i < NS; i++) begin
                if (vin[i] && rdy_pre[i]) begin
                    mq[i].push_back(clr_t'({vw[i], vs[i]}));
                    acc[i] = 1'b1;
                end
            end
        end
        @(negedge clk);
        for (int i = 0; i < NS; i++) begin
            check("ready", int'(bus.Clear_Ready_Out[i]), int'(mq[i].size() < DEPTH));
            check("pending", int'(bus.Pending_Out[i]), int'(mq[i].size() > 0));
        end
        check("clear_valid", int'(bus.Clear_Valid_ALU_Scb), int'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            it     = exp_q.pop_front();
            m_warp = it.w;
            m_scb  = it.s;
        end
        check("clear_warp", int'(bus.Clear_WarpID_ALU_Scb), int'(m_warp));
        check("clear_scb", int'(bus.Clear_ScbID_ALU_Scb), int'(m_scb));
    endtask

    function automatic vec_t mk(input logic [2:0] mask,
                                input logic [2:0] w0, input logic [1:0] s0,
                                input logic [2:0] w1, input logic [1:0] s1,
                                input logic [2:0] w2, input logic [1:0] s2,
                                input logic [1:0] n,
                                input logic [2:0] e0w, input logic [1:0] e0s,
                                input logic [2:0] e1w, input logic [1:0] e1s,
                                input logic [2:0] e2w, input logic [1:0] e2s);
        vec_t r;
        r.mask = mask;
        r.w[0] = w0;  r.s[0] = s0;
        r.w[1] = w1;  r.s[1] = s1;
        r.w[2] = w2;  r.s[2] = s2;
        r.n     = n;
        r.ew[0] = e0w; r.es[0] = e0s;
        r.ew[1] = e1w; r.es[1] = e1s;
        r.ew[2] = e2w; r.es[2] = e2s;
        return r;
    endfunction

    initial begin
        vec_t       tbl [6];
        int         d [NS];
        logic       saw_low;
        int         prev_src;
        for (int i = 0; i < NS; i++) begin
            vw[i] = '0;
            vs[i] = '0;
            d[i]  = 0;
        end

        // Each record starts from idle; output order follows the RR pointer
        // left behind by the previous record (pointer = 2 after reset).
        tbl[0] = mk(3'b111, 3'd1, 2'd0, 3'd2, 2'd1, 3'd5, 2'd3, 2'd3,
                    3'd1, 2'd0, 3'd2, 2'd1, 3'd5, 2'd3);
        tbl[1] = mk(3'b001, 3'd3, 2'd2, 3'd0, 2'd0, 3'd0, 2'd0, 2'd1,
                    3'd3, 2'd2, 3'd0, 2'd0, 3'd0, 2'd0);
        tbl[2] = mk(3'b110, 3'd0, 2'd0, 3'd7, 2'd1, 3'd4, 2'd0, 2'd2,
                    3'd7, 2'd1, 3'd4, 2'd0, 3'd0, 2'd0);
        tbl[3] = mk(3'b101, 3'd0, 2'd1, 3'd0, 2'd0, 3'd6, 2'd3, 2'd2,
                    3'd0, 2'd1, 3'd6, 2'd3, 3'd0, 2'd0);
        tbl[4] = mk(3'b010, 3'd0, 2'd0, 3'd2, 2'd2, 3'd0, 2'd0, 2'd1,
                    3'd2, 2'd2, 3'd0, 2'd0, 3'd0, 2'd0);
        tbl[5] = mk(3'b111, 3'd4, 2'd1, 3'd5, 2'd2, 3'd6, 2'd3, 2'd3,
                    3'd6, 2'd3, 3'd4, 2'd1, 3'd5, 2'd2);

        // Reset held for two cycles.
        rst = 1'b1;
        step();
        step();
        check("rst_ready", int'(bus.Clear_Ready_Out), 7);
        check("rst_pending", int'(bus.Pending_Out), 0);
        check("rst_valid", int'(bus.Clear_Valid_ALU_Scb), 0);
        check("rst_warp", int'(bus.Clear_WarpID_ALU_Scb), 0);
        check("rst_scb", int'(bus.Clear_ScbID_ALU_Scb), 0);
        rst = 1'b0;
        step();

        // Table: single-edge pushes, then exact per-cycle output sequence.
        for (int r = 0; r < 6; r++) begin
            vin = tbl[r].mask;
            for (int i = 0; i < NS; i++) begin
                vw[i] = tbl[r].w[i];
                vs[i] = tbl[r].s[i];
            end
            step();
            vin = '0;
            check("tbl_pending", int'(bus.Pending_Out), int'(tbl[r].mask));
            for (int j = 0; j < 4; j++) begin
                step();
                if (j < int'(tbl[r].n)) begin
                    check("tbl_valid", int'(bus.Clear_Valid_ALU_Scb), 1);
                    check("tbl_warp", int'(bus.Clear_WarpID_ALU_Scb), int'(tbl[r].ew[j]));
                    check("tbl_scb", int'(bus.Clear_ScbID_ALU_Scb), int'(tbl[r].es[j]));
                end else begin
                    check("tbl_idle", int'(bus.Clear_Valid_ALU_Scb), 0);
                end
            end
        end

        // Fill: src0 and src1 push every cycle; data advances only on accept.
        saw_low = 1'b0;
        vin = 3'b011;
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < 2; i++) begin
                vw[i] = 3'(d[i]);
                vs[i] = 2'(i);
            end
            step();
            for (int i = 0; i < 2; i++) if (acc[i]) d[i]++;
            if (!bus.Clear_Ready_Out[0] || !bus.Clear_Ready_Out[1]) saw_low = 1'b1;
        end
        vin = '0;
        for (int c = 0; c < 12; c++) step();
        check("fill_ready_dropped", int'(saw_low), 1);
        check("fill_drained", int'(bus.Pending_Out), 0);

        // Fairness: all sources kept pending; scb field carries the source id.
        prev_src = -1;
        vin = 3'b111;
        for (int c = 0; c < 14; c++) begin
            for (int i = 0; i < NS; i++) begin
                vw[i] = 3'(d[i]);
                vs[i] = 2'(i);
            end
            step();
            for (int i = 0; i < NS; i++) if (acc[i]) d[i]++;
            if (bus.Clear_Valid_ALU_Scb) begin
                if (prev_src >= 0)
                    check("rr_rotate", int'(bus.Clear_ScbID_ALU_Scb), (prev_src + 1) % NS);
                prev_src = int'(bus.Clear_ScbID_ALU_Scb);
            end
        end
        vin = '0;
        for (int c = 0; c < 16; c++) step();
        check("fair_drained", int'(bus.Pending_Out), 0);

        // Reset with entries queued in src1 (and others).
        vin = 3'b111;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < NS; i++) begin
                vw[i] = 3'(c + i);
                vs[i] = 2'(i);
            end
            step();
        end
        check("mid_src1_queued", int'(bus.Pending_Out[1]), 1);
        vin = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", int'(bus.Clear_Valid_ALU_Scb), 0);
        check("mid_rst_ready", int'(bus.Clear_Ready_Out), 7);
        check("mid_rst_pending", int'(bus.Pending_Out), 0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("mid_quiet", int'(bus.Clear_Valid_ALU_Scb), 0);
        end
        vin   = 3'b010;
        vw[1] = 3'd6;
        vs[1] = 2'd1;
        step();
        vin = '0;
        step();
        check("post_rst_valid", int'(bus.Clear_Valid_ALU_Scb), 1);
        check("post_rst_warp", int'(bus.Clear_WarpID_ALU_Scb), 6);
        check("post_rst_scb", int'(bus.Clear_ScbID_ALU_Scb), 1);
        step();
        check("post_rst_single", int'(bus.Clear_Valid_ALU_Scb), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
